// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, requester id and operation kind.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitBusy,
      StWaitDone,
      StResp
   } arb_state_t;

   typedef logic req_id_t;

   typedef enum logic {
      OpRd,
      OpWr
   } op_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a tie goes to the requester that did not win last time.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  req_id_t    last_i,
   output logic [1:0] gnt_o,
   output req_id_t    last_o
);

   // last_o is the pointer value to load when this grant is taken.
   always_comb begin
      gnt_o  = 2'b00;
      last_o = last_i;
      if (req_i == 2'b11) begin
         gnt_o  = last_i ? 2'b01 : 2'b10;
         last_o = ~last_i;
      end else if (req_i[0]) begin
         gnt_o  = 2'b01;
         last_o = 1'b0;
      end else if (req_i[1]) begin
         gnt_o  = 2'b10;
         last_o = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memx host port between two requesters, one transaction at a time, with
// round-robin arbitration and per-requester routing of read data and write acknowledges.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned RAM_DATA_WIDTH = 16,
   parameter int unsigned RAM_ADDR_WIDTH = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req0_rd_i,
   input  logic                      req0_wr_i,
   input  logic [RAM_ADDR_WIDTH-1:0] req0_addr_i,
   input  logic [RAM_DATA_WIDTH-1:0] req0_wdt_i,
   output logic                      req0_gnt_o,
   output logic                      req0_rvalid_o,
   output logic [RAM_DATA_WIDTH-1:0] req0_rdt_o,
   output logic                      req0_wok_o,
   input  logic                      req1_rd_i,
   input  logic                      req1_wr_i,
   input  logic [RAM_ADDR_WIDTH-1:0] req1_addr_i,
   input  logic [RAM_DATA_WIDTH-1:0] req1_wdt_i,
   output logic                      req1_gnt_o,
   output logic                      req1_rvalid_o,
   output logic [RAM_DATA_WIDTH-1:0] req1_rdt_o,
   output logic                      req1_wok_o,
   output logic                      mem_rd_o,
   output logic                      mem_wr_o,
   output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
   output logic [RAM_DATA_WIDTH-1:0] mem_wdt_o,
   input  logic                      mem_busy_i,
   input  logic [RAM_DATA_WIDTH-1:0] mem_rdt_i,
   input  logic                      mem_wok_i
);

   arb_state_t                state_q, state_d;
   req_id_t                   last_q, last_d;
   req_id_t                   id_q, id_d;
   op_t                       op_q, op_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RAM_DATA_WIDTH-1:0] wdt_q, wdt_d;
   logic [RAM_DATA_WIDTH-1:0] rdt0_q, rdt0_d;
   logic [RAM_DATA_WIDTH-1:0] rdt1_q, rdt1_d;

   logic [1:0] arb_req;
   logic [1:0] arb_gnt;
   req_id_t    arb_last;

   assign arb_req = {req1_rd_i | req1_wr_i, req0_rd_i | req0_wr_i};

   rr_arb2 u_rr_arb2 (
      .req_i  (arb_req),
      .last_i (last_q),
      .gnt_o  (arb_gnt),
      .last_o (arb_last)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         op_q    <= OpRd;
         addr_q  <= '0;
         wdt_q   <= '0;
         rdt0_q  <= '0;
         rdt1_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdt_q   <= wdt_d;
         rdt0_q  <= rdt0_d;
         rdt1_q  <= rdt1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdt_d   = wdt_q;
      rdt0_d  = rdt0_q;
      rdt1_d  = rdt1_q;
      case (state_q)
         StIdle: begin
            if ((|arb_req) && !mem_busy_i) begin
               state_d = StIssue;
               last_d  = arb_last;
               id_d    = arb_last;
               // A simultaneous rd+wr is treated as a read.
               if (arb_gnt[0]) begin
                  op_d   = req0_rd_i ? OpRd : OpWr;
                  addr_d = req0_addr_i;
                  wdt_d  = req0_wdt_i;
               end else begin
                  op_d   = req1_rd_i ? OpRd : OpWr;
                  addr_d = req1_addr_i;
                  wdt_d  = req1_wdt_i;
               end
            end
         end
         StIssue: state_d = StWaitBusy;
         StWaitBusy: begin
            if (op_q == OpWr && mem_wok_i) begin
               state_d = StResp;
            end else if (mem_busy_i) begin
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (op_q == OpRd) begin
               if (!mem_busy_i) begin
                  state_d = StResp;
                  if (id_q) rdt1_d = mem_rdt_i;
                  else      rdt0_d = mem_rdt_i;
               end
            end else if (mem_wok_i) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_rd_o      = (state_q == StIssue) && (op_q == OpRd);
      mem_wr_o      = (state_q == StIssue) && (op_q == OpWr);
      mem_addr_o    = addr_q;
      mem_wdt_o     = wdt_q;
      req0_gnt_o    = (state_q == StIssue) && !id_q;
      req1_gnt_o    = (state_q == StIssue) && id_q;
      req0_rvalid_o = (state_q == StResp) && !id_q && (op_q == OpRd);
      req1_rvalid_o = (state_q == StResp) && id_q && (op_q == OpRd);
      req0_wok_o    = (state_q == StResp) && !id_q && (op_q == OpWr);
      req1_wok_o    = (state_q == StResp) && id_q && (op_q == OpWr);
      req0_rdt_o    = rdt0_q;
      req1_rdt_o    = rdt1_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a stand-in memx controller and a transaction-level
// reference model (round-robin order plus a word array for expected read data).
module tb_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_rd, req0_wr, req1_rd, req1_wr;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_wdt, req1_wdt;
   logic          req0_gnt, req0_rvalid, req0_wok, req1_gnt, req1_rvalid, req1_wok;
   logic [DW-1:0] req0_rdt, req1_rdt;
   logic          mem_rd, mem_wr, mem_busy, mem_wok;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdt, mem_rdt;

   logic          ctl_busy, force_busy;
   int            busy_extra;
   int            checks = 0;
   int            failures = 0;
   int            rd_cnt = 0;
   int            wr_cnt = 0;
   logic [DW-1:0] ref_mem [0:1023];
   logic [DW-1:0] ctl_mem [0:1023];
   bit            last_m;

   always #5 clk = ~clk;
   assign mem_busy = ctl_busy | force_busy;

   mem_arbiter #(.RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_rd_i(req0_rd), .req0_wr_i(req0_wr), .req0_addr_i(req0_addr), .req0_wdt_i(req0_wdt),
      .req0_gnt_o(req0_gnt), .req0_rvalid_o(req0_rvalid), .req0_rdt_o(req0_rdt),
      .req0_wok_o(req0_wok),
      .req1_rd_i(req1_rd), .req1_wr_i(req1_wr), .req1_addr_i(req1_addr), .req1_wdt_i(req1_wdt),
      .req1_gnt_o(req1_gnt), .req1_rvalid_o(req1_rvalid), .req1_rdt_o(req1_rdt),
      .req1_wok_o(req1_wok),
      .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdt_o(mem_wdt),
      .mem_busy_i(mem_busy), .mem_rdt_i(mem_rdt), .mem_wok_i(mem_wok)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      if (i == 5) return 16'h1010;
      return DW'((i * 37) ^ 16'h5a5a);
   endfunction

   // Stand-in controller: busy rises 1..4 cycles after sampling, stays high a few cycles.
   bit            c_loaded = 1'b0;
   bit            c_pend, c_wr;
   int            c_pre, c_len;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if (!c_loaded) begin
            for (int i = 0; i < 1024; i++) ctl_mem[i] <= init_word(i);
            c_loaded <= 1'b1;
         end
         c_pend   <= 1'b0;
         ctl_busy <= 1'b0;
         mem_wok  <= 1'b0;
         mem_rdt  <= '0;
      end else begin
         mem_wok <= 1'b0;
         if (!c_pend) begin
            if (!mem_busy && (mem_rd || mem_wr)) begin
               c_pend <= 1'b1;
               c_wr   <= mem_wr && !mem_rd;
               c_addr <= mem_addr;
               c_wdt  <= mem_wdt;
               c_pre  <= int'($urandom_range(0, 3));
               c_len  <= int'($urandom_range(1, 3)) + busy_extra;
            end
         end else if (c_pre > 0) begin
            c_pre <= c_pre - 1;
         end else if (!ctl_busy) begin
            ctl_busy <= 1'b1;
         end else if (c_len > 1) begin
            c_len <= c_len - 1;
         end else begin
            ctl_busy <= 1'b0;
            c_pend   <= 1'b0;
            if (c_wr) begin
               ctl_mem[c_addr] <= c_wdt;
               mem_wok         <= 1'b1;
            end else begin
               mem_rdt <= ctl_mem[c_addr];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && mem_rd) rd_cnt <= rd_cnt + 1;
      if (rst_n && mem_wr) wr_cnt <= wr_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply up to two requests at once and check grant order, responses and controller pulses.
   task automatic do_round(input bit v0, input bit r0, input bit w0, input logic [AW-1:0] a0,
                           input logic [DW-1:0] d0, input bit v1, input bit r1, input bit w1,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1, output int lat);
      logic [1:0]    pend;
      bit            e, got, isrd;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, rdt;
      logic [3:0]    rv, expv;
      int            rd0 = rd_cnt;
      int            wr0 = wr_cnt;
      int            exp_rd = 0;
      int            exp_wr = 0;
      req0_rd = v0 & r0; req0_wr = v0 & w0; req0_addr = a0; req0_wdt = d0;
      req1_rd = v1 & r1; req1_wr = v1 & w1; req1_addr = a1; req1_wdt = d1;
      pend = {v1, v0};
      lat  = -1;
      while (pend != 2'b00) begin
         e   = (pend == 2'b11) ? ~last_m : pend[1];
         got = 1'b0;
         for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req0_gnt || req1_gnt) begin
               got = 1'b1;
               if (lat < 0) lat = i;
               break;
            end
         end
         check("gnt_onehot", 32'({req1_gnt, req0_gnt}), e ? 32'd2 : 32'd1);
         if (!got) break;
         last_m = e;
         isrd   = e ? r1 : r0;
         ea     = e ? a1 : a0;
         ed     = e ? d1 : d0;
         if (e) begin req1_rd = 1'b0; req1_wr = 1'b0; end
         else begin req0_rd = 1'b0; req0_wr = 1'b0; end
         pend[e] = 1'b0;
         if (isrd) exp_rd++; else exp_wr++;
         rv = 4'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rv = {req1_rvalid, req1_wok, req0_rvalid, req0_wok};
            if (rv != 4'b0) break;
         end
         expv = e ? (isrd ? 4'b1000 : 4'b0100) : (isrd ? 4'b0010 : 4'b0001);
         check("resp", 32'(rv), 32'(expv));
         if (isrd) begin
            rdt = e ? req1_rdt : req0_rdt;
            check("rdt", 32'(rdt), 32'(ref_mem[ea]));
         end else begin
            ref_mem[ea] = ed;
         end
      end
      repeat (2) @(negedge clk);
      check("mem_rd_pulses", 32'(rd_cnt - rd0), 32'(exp_rd));
      check("mem_wr_pulses", 32'(wr_cnt - wr0), 32'(exp_wr));
   endtask

   initial begin
      int            lat, cnt;
      bit            seen, v0, v1, r0, r1, w0, w1;
      int            k;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      req0_rd = 0; req0_wr = 0; req0_addr = '0; req0_wdt = '0;
      req1_rd = 0; req1_wr = 0; req1_addr = '0; req1_wdt = '0;
      force_busy = 1'b0; busy_extra = 0; last_m = 1'b1;
      rst_n = 1'b0;
      #1;
      check("reset_outs", 32'(|{req0_gnt, req0_rvalid, req0_rdt, req0_wok, req1_gnt,
                                 req1_rvalid, req1_rdt, req1_wok, mem_rd, mem_wr, mem_addr,
                                 mem_wdt}), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Ties: req0 first out of reset, then alternating.
      for (int t = 0; t < 10; t++)
         do_round(1, 1, 0, AW'($urandom), '0, 1, 1, 0, AW'($urandom), '0, lat);

      do_round(1, 1, 0, 10'h005, '0, 0, 0, 0, '0, '0, lat);
      check("gnt_latency", 32'(lat), 32'd1);
      check("read_005", 32'(req0_rdt), 32'h1010);

      do_round(0, 0, 0, '0, '0, 1, 0, 1, 10'h3ff, 16'hbeef, lat);
      do_round(0, 0, 0, '0, '0, 1, 1, 0, 10'h3ff, '0, lat);
      check("read_3ff", 32'(req1_rdt), 32'hbeef);

      // Controller busy while req0 waits: nothing may be issued.
      force_busy = 1'b1;
      req0_rd = 1'b1; req0_addr = 10'h005;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         seen = seen | req0_gnt | req1_gnt | mem_rd | mem_wr;
      end
      check("busy_hold", 32'(seen), 32'd0);
      force_busy = 1'b0;
      do_round(1, 1, 0, 10'h005, '0, 0, 0, 0, '0, '0, lat);
      check("gnt_after_busy", 32'(lat), 32'd1);

      // Illegal rd+wr: must be a plain read.
      do_round(1, 1, 1, 10'h010, 16'h1234, 0, 0, 0, '0, '0, lat);
      do_round(1, 1, 0, 10'h010, '0, 0, 0, 0, '0, '0, lat);

      // Reset while waiting on the controller.
      busy_extra = 4;
      req0_rd = 1'b1; req0_addr = 10'h005;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = req0_gnt;
      end
      check("mid_gnt", 32'(seen), 32'd1);
      req0_rd = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = mem_busy;
      end
      check("mid_busy", 32'(seen), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_reset_outs", 32'(|{req0_gnt, req0_rvalid, req0_rdt, req0_wok, req1_gnt,
                                     req1_rvalid, req1_rdt, req1_wok, mem_rd, mem_wr,
                                     mem_addr, mem_wdt}), 32'd0);
      last_m = 1'b1;
      busy_extra = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         cnt += int'(req0_rvalid) + int'(req1_rvalid) + int'(req0_wok) + int'(req1_wok);
      end
      check("no_resp_after_reset", 32'(cnt), 32'd0);
      do_round(1, 1, 0, 10'h005, '0, 0, 0, 0, '0, '0, lat);
      check("fresh_read", 32'(req0_rdt), 32'h1010);

      // Random mix of single and contending requests.
      for (int t = 0; t < 40; t++) begin
         v0 = 1'($urandom); v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1'b1;
         k = int'($urandom_range(0, 7));
         r0 = (k < 4); w0 = (k == 0) || (k >= 4);
         k = int'($urandom_range(0, 7));
         r1 = (k < 4); w1 = (k == 0) || (k >= 4);
         do_round(v0, r0, w0, AW'($urandom_range(0, 31)), DW'($urandom),
                  v1, r1, w1, AW'($urandom_range(0, 31)), DW'($urandom), lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the host side of the memory controller (`memx`) between two requesters, e.g. a bus master and a DMA/test engine. It issues one transaction at a time, holds the controller interface stable while the controller is busy, and routes the read data or write acknowledge back to the requester that owns the transaction. It sits directly above `memx`, which drives `mem_fpga`.

## Interface
- `RAM_DATA_WIDTH`, 16, data word width; must match `memx`.
- `RAM_ADDR_WIDTH`, 10, word address width; must match `memx`.
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `reqN_rd_i`  in  1  (N=0,1) read request; held high until `reqN_gnt_o`.
- `reqN_wr_i`  in  1  write request; held high until `reqN_gnt_o`.
- `reqN_addr_i`  in  RAM_ADDR_WIDTH  word address; stable while the request is high.
- `reqN_wdt_i`  in  RAM_DATA_WIDTH  write data; stable while the request is high.
- `reqN_gnt_o`  out  1  one-cycle pulse; the request is accepted and its inputs are latched.
- `reqN_rvalid_o`  out  1  one-cycle pulse; `reqN_rdt_o` holds the read result.
- `reqN_rdt_o`  out  RAM_DATA_WIDTH  read data; holds its value until the next read response to N.
- `reqN_wok_o`  out  1  one-cycle pulse; the write has completed.
- `mem_rd_o`, `mem_wr_o`  out  1  connect to `memx` `mem_rd_i`, `mem_wr_i`.
- `mem_addr_o`  out  RAM_ADDR_WIDTH  connects to `mem_addr_i`.
- `mem_wdt_o`  out  RAM_DATA_WIDTH  connects to `mem_wdt_i`.
- `mem_busy_i`  in  1  from `mem_busy_o`.
- `mem_rdt_i`  in  RAM_DATA_WIDTH  from `mem_rdt_o`.
- `mem_wok_i`  in  1  from `mem_wok_o`.

## Operation
- **Controller contract.**
  - `memx` samples `mem_rd`/`mem_wr` only while `mem_busy` is low.
  - It raises `mem_busy` within 1..4 cycles of sampling a request.
  - Read completion: the first cycle `mem_busy` is low after having been high; `mem_rdt` is valid in that cycle.
  - Write completion: a one-cycle pulse on `mem_wok`.
- **States.** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- **IDLE.** Any request present and `mem_busy_i` low: arbitrate, latch the winner's id, op, address and data, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE.** One cycle.
  - `mem_rd_o` or `mem_wr_o` is high.
  - `mem_addr_o`/`mem_wdt_o` come from the latch.
  - The winner's `gnt_o` is high.
  - Then go to WAIT_BUSY.
- **WAIT_BUSY.** Stay until `mem_busy_i` is high, then go to WAIT_DONE.
  - A write whose `mem_wok_i` pulses here counts as complete: go straight to RESP.
- **WAIT_DONE.**
  - Read: when `mem_busy_i` is low, capture `mem_rdt_i` and go to RESP.
  - Write: when `mem_wok_i` is high, go to RESP.
- **RESP.** One cycle. The owner's `rvalid_o` or `wok_o` pulses; the owner's `rdt_o` updates on reads. Then go to IDLE.
- **Arbitration.** Round-robin with a `last` pointer updated on every grant.
  - With both requesting, the winner is the requester not equal to `last`.
  - Reset value of `last` is 1, so req0 wins the first tie.
- **Simultaneous rd and wr from one requester.** Illegal; the transaction is a read and the write is dropped.
- **Request withdrawn before grant.** Allowed; no effect.
- **Hold rule.** `mem_addr_o`/`mem_wdt_o` stay at the latched value from ISSUE through RESP.
- **Reset (including mid-transaction).**
  - All outputs are 0, the state is IDLE and `last` is 1.
  - An in-flight transaction is abandoned and produces no response.

## Timing
- Request high at edge k in IDLE with `mem_busy_i` low: `gnt_o` and `mem_rd_o`/`mem_wr_o` are high in cycle k+1.
- Response pulse: one cycle after completion is detected.
- Read latency with 2-cycle controller busy: gnt at k+1, busy k+2..k+3, completion k+4, `rvalid_o` k+5.
- Back-to-back transactions: at least one IDLE cycle between RESP and the next ISSUE.
- No combinational path from any requester input to any `mem_*_o` output.

## Structure
- Package `mem_arb_pkg`: state enum `arb_state_t`; `req_id_t` (1 bit); `op_t` (RD, WR).
- Sub-module `rr_arb2`: two request bits plus the `last` pointer in, one-hot grant out, pointer update on grant. The FSM and datapath stay in `mem_arbiter`.

## Test plan
- **Single read.** Preload mem[0x005]=0x1010; req0 read 0x005 → one `req0_gnt_o` pulse, `req0_rvalid_o` once with `req0_rdt_o`=0x1010, req1 outputs stay 0.
- **Write then read.** req1 writes 0x3FF←0xBEEF → `req1_wok_o` pulse; req1 reads 0x3FF → 0xBEEF.
- **Tie from reset.** Both issue reads in the same cycle → req0 granted first, req1 second. A second tie → req1 first. Grants alternate across 8 consecutive ties.
- **Busy at request.** Controller busy held high 5 cycles while req0 waits → no `mem_rd_o`/`mem_wr_o` pulse and no grant until the cycle after busy falls.
- **Reset mid-read.** Assert `rst_ni` low in WAIT_DONE → all outputs 0 immediately. After release: no `rvalid_o`, and a fresh req0 read completes normally.
- **Illegal rd+wr.** req0 asserts `req0_rd_i` and `req0_wr_i` at 0x010 → exactly one `mem_rd_o` pulse, never `mem_wr_o`, memory contents unchanged.
